// File: rtl/instr_mem_banked.sv
// Byte-banked instruction memory with valid/ready fetch, stall hold and a byte-serial program port.
// Define INSTR_MEM_OUTREG_EN to add a second output register stage (read latency 2).
module instr_mem_banked #(
  parameter int          NUM_LANES = 4,
  parameter int          DEPTH_W   = 8,
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  parameter string       INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [31:0]            fetch_addr,
  output logic                   fetch_ready,
  output logic [8*NUM_LANES-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rstall,
  output logic                   fault,
  input  logic                   prog_we,
  input  logic [31:0]            prog_addr,
  input  logic [7:0]             prog_byte
);

  localparam int W     = 8 * NUM_LANES;
  localparam int L     = $clog2(NUM_LANES);
  localparam int WORDS = 1 << DEPTH_W;
  localparam logic [63:0]  NOP64 = 64'(NOP_WORD);
  localparam logic [W-1:0] NOP   = NOP64[W-1:0];

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  function automatic logic [DEPTH_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] s;
    s = a >> L;
    return s[DEPTH_W-1:0];
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (DEPTH_W + L)) == 32'd0;
  endfunction

  function automatic logic aligned(input logic [31:0] a);
    return (a & 32'(NUM_LANES - 1)) == 32'd0;
  endfunction

  state_t         state;
  logic           stall_out;
  logic           accept;
  logic           fetch_fault;
  logic           load;
  logic [W-1:0]   bank_p1;
  logic           fault_p1;
  logic [W-1:0]   word_p1;
  logic [W-1:0]   out_word;
  logic           out_fault;

  // Writes take priority over fetches, so a bank never sees read and write together.
  assign stall_out   = rvalid && rstall;
  assign fetch_ready = !prog_we && !stall_out;
  assign accept      = fetch_req && fetch_ready;
  assign fetch_fault = !aligned(fetch_addr) || !in_range(fetch_addr);

  // Stage p1: synchronous bank read, one byte-wide RAM per lane
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] rd_p1;

    always_ff @(posedge clk) begin
      if (prog_we && in_range(prog_addr) && ((prog_addr & 32'(NUM_LANES - 1)) == 32'(g)))
        mem[word_idx(prog_addr)] <= prog_byte;
      if (accept && !fetch_fault)
        rd_p1 <= mem[word_idx(fetch_addr)];
    end

    assign bank_p1[8*g +: 8] = rd_p1;
  end

  always_ff @(posedge clk) begin
    if (accept)
      fault_p1 <= fetch_fault;
  end

  assign word_p1 = fault_p1 ? NOP : bank_p1;

`ifdef INSTR_MEM_OUTREG_EN
  // Stage p2: output register; both stages freeze while the consumer stalls
  logic         vld_p1;
  logic [W-1:0] word_p2;
  logic         fault_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      vld_p1 <= 1'b0;
    else if (!stall_out)
      vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (!stall_out) begin
      word_p2  <= word_p1;
      fault_p2 <= fault_p1;
    end
  end

  assign load      = vld_p1 && !stall_out;
  assign out_word  = word_p2;
  assign out_fault = fault_p2;
`else
  assign load      = accept;
  assign out_word  = word_p1;
  assign out_fault = fault_p1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rvalid <= 1'b0;
    end else if (load) begin
      state  <= RESP;
      rvalid <= 1'b1;
    end else if (state != IDLE && rstall) begin
      state  <= HOLD;
      rvalid <= 1'b1;
    end else begin
      state  <= IDLE;
      rvalid <= 1'b0;
    end
  end

  // Gating by rvalid gives zero outputs straight out of reset without resetting the datapath.
  assign rdata = rvalid ? out_word : '0;
  assign fault = rvalid && out_fault;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Randomised scoreboard bench for instr_mem_banked (default build, 4 lanes, 256 words).
module tb_instr_mem_banked;

  localparam int BYTES = 1024;

  typedef struct packed {
    logic        f;
    logic [31:0] d;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rstall;
  logic        fault;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [7:0]  prog_byte;

  logic [7:0] ref_mem [BYTES];
  resp_t      exp_q [$];
  bit         model_valid;
  int         checks;
  int         failures;

  always #5 clk = ~clk;

  instr_mem_banked dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rstall     (rstall),
    .fault      (fault),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_byte  (prog_byte)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic resp_t predict(input logic [31:0] a);
    resp_t r;
    if (a[1:0] != 2'b00 || a >= 32'(BYTES)) begin
      r.f = 1'b1;
      r.d = 32'h00000013;
    end else begin
      r.f = 1'b0;
      r.d = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    end
    return r;
  endfunction

  // Monitor compares the presented response, then records what the coming edge issues.
  always @(negedge clk) begin
    bit acc;
    if (reset) begin
      model_valid = 1'b0;
      exp_q.delete();
    end else begin
      chk("rvalid", {31'd0, rvalid}, {31'd0, model_valid});
      chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, !prog_we && !(model_valid && rstall)});
      if (model_valid && exp_q.size() > 0) begin
        chk("rdata", rdata, exp_q[0].d);
        chk("fault", {31'd0, fault}, {31'd0, exp_q[0].f});
        if (!rstall) void'(exp_q.pop_front());
      end
      acc = fetch_req && !prog_we && !(model_valid && rstall);
      if (acc) exp_q.push_back(predict(fetch_addr));
      if (prog_we && prog_addr < 32'(BYTES)) ref_mem[prog_addr] = prog_byte;
      model_valid = acc || (model_valid && rstall);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] b);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_byte = b;
    step();
    prog_we = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) wr(a + 32'(i), w[8*i +: 8]);
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
  endtask

  localparam logic [31:0] WA = 32'hA1A2A3A4;
  localparam logic [31:0] WB = 32'hB5B6B7B8;
  localparam logic [31:0] WC = 32'hC9CACBCC;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    fetch_req = 1'b0;
    fetch_addr = '0;
    rstall = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_byte = '0;
    #1;
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    repeat (2) step();
    reset = 1'b0;

    for (int i = 0; i < BYTES; i++) wr(32'(i), 8'($urandom));

    wr(32'h10, 8'h13); wr(32'h11, 8'h00); wr(32'h12, 8'h00); wr(32'h13, 8'h00);
    fetch(32'h10);
    chk("prog_fetch_rvalid", {31'd0, rvalid}, 32'd1);
    chk("prog_fetch_rdata", rdata, 32'h00000013);
    chk("prog_fetch_fault", {31'd0, fault}, 32'd0);

    wr_word(32'h0, WA); wr_word(32'h4, WB); wr_word(32'h8, WC);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    chk("stream_a", rdata, WA);
    fetch_addr = 32'h4;
    step();
    chk("stream_b", rdata, WB);
    fetch_addr = 32'h8;
    rstall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdata", rdata, WB);
      chk("stall_ready", {31'd0, fetch_ready}, 32'd0);
      chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
    end
    rstall = 1'b0;
    step();
    chk("stream_c", rdata, WC);
    fetch_req = 1'b0;
    step();

    fetch(32'h6);
    chk("misalign_fault", {31'd0, fault}, 32'd1);
    chk("misalign_rdata", rdata, 32'h00000013);
    fetch(32'h400);
    chk("range_fault", {31'd0, fault}, 32'd1);
    chk("range_rdata", rdata, 32'h00000013);
    fetch(32'h4);
    chk("after_fault_b", rdata, WB);
    chk("after_fault_ok", {31'd0, fault}, 32'd0);

    fetch_req = 1'b1; fetch_addr = 32'h20;
    prog_we = 1'b1; prog_addr = 32'h21; prog_byte = 8'h5A;
    #1;
    chk("collide_ready", {31'd0, fetch_ready}, 32'd0);
    step();
    prog_we = 1'b0;
    chk("collide_noresp", {31'd0, rvalid}, 32'd0);
    step();
    fetch_req = 1'b0;
    chk("collide_rvalid", {31'd0, rvalid}, 32'd1);
    chk("collide_lane1", {24'd0, rdata[15:8]}, 32'h5A);

    fetch(32'h6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rvalid", {31'd0, rvalid}, 32'd0);
    chk("async_fault", {31'd0, fault}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    step();
    reset = 1'b0;
    step();

    for (int n = 0; n < 3000; n++) begin
      int r;
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 32'($urandom_range(0, 1100));
      prog_byte = 8'($urandom);
      fetch_req = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       fetch_addr = {22'd0, 8'($urandom), 2'b00};
      else if (r == 7) fetch_addr = 32'($urandom_range(0, 1023));
      else if (r == 8) fetch_addr = 32'h400 + 32'($urandom_range(0, 255));
      else             fetch_addr = $urandom;
      rstall = ($urandom_range(0, 3) == 0);
      step();
    end

    fetch_req = 1'b0;
    prog_we = 1'b0;
    rstall = 1'b0;
    repeat (4) step();
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
